// File: rtl/onchip_ram_pkg.sv
// Shared types and constants for the two-port on-chip RAM slice.
package onchip_ram_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        READY = 2'd2
    } clr_state_e;

    localparam int RD_LAT_1 = 1;
    localparam int RD_LAT_2 = 2;

endpackage

// File: rtl/onchip_ram_2p_array.sv
// True dual-port, byte-enabled storage with registered, read-enabled outputs.
module onchip_ram_2p_array #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 8
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  a_we_i,
    input  logic                  a_re_i,
    input  logic [DATA_W/8-1:0]   a_be_i,
    input  logic [ADDR_W-1:0]     a_addr_i,
    input  logic [DATA_W-1:0]     a_wdata_i,
    output logic [DATA_W-1:0]     a_rdata_o,
    input  logic                  b_we_i,
    input  logic                  b_re_i,
    input  logic [DATA_W/8-1:0]   b_be_i,
    input  logic [ADDR_W-1:0]     b_addr_i,
    input  logic [DATA_W-1:0]     b_wdata_i,
    output logic [DATA_W-1:0]     b_rdata_o
);

    localparam int BE_W  = DATA_W / 8;
    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];

    // NOTE: the array has no reset; clearing it is the job of the sweep, and a reset term would block RAM inference.
    always_ff @(posedge clk) begin
        for (int i = 0; i < BE_W; i++) begin
            if (a_we_i && a_be_i[i]) begin
                mem[a_addr_i][8*i +: 8] <= a_wdata_i[8*i +: 8];
            end
            if (b_we_i && b_be_i[i] && !(a_we_i && a_be_i[i] && (a_addr_i == b_addr_i))) begin
                mem[b_addr_i][8*i +: 8] <= b_wdata_i[8*i +: 8];
            end
        end
    end

    // Read registers only load on an accepted read, so they hold between reads.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            a_rdata_o <= '0;
            b_rdata_o <= '0;
        end else begin
            if (a_re_i) a_rdata_o <= mem[a_addr_i];
            if (b_re_i) b_rdata_o <= mem[b_addr_i];
        end
    end

endmodule

// File: rtl/onchip_ram_2p.sv
// Two-port RAM wrapper: request acceptance, read-valid pipelines, port B write-first bypass and post-reset clear sweep.
module onchip_ram_2p
    import onchip_ram_pkg::*;
#(
    parameter int DATA_W         = 32,
    parameter int ADDR_W         = 8,
    parameter int READ_LATENCY   = 1,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  a_chipselect,
    input  logic                  a_read,
    input  logic                  a_write,
    input  logic [ADDR_W-1:0]     a_address,
    input  logic [DATA_W/8-1:0]   a_byteenable,
    input  logic [DATA_W-1:0]     a_writedata,
    output logic [DATA_W-1:0]     a_readdata,
    output logic                  a_readdatavalid,
    output logic                  a_waitrequest,
    input  logic                  b_chipselect,
    input  logic                  b_read,
    input  logic [ADDR_W-1:0]     b_address,
    output logic [DATA_W-1:0]     b_readdata,
    output logic                  b_readdatavalid,
    output logic                  b_waitrequest,
    output logic                  clear_done
);

    localparam int BE_W = DATA_W / 8;

    clr_state_e          state_q, state_d;
    logic [ADDR_W:0]     clr_cnt_q, clr_cnt_d;
    logic                clr_we;
    logic                ready;

    logic                a_wr_acc, a_rd_acc, b_rd_acc;

    logic                arr_a_we;
    logic [BE_W-1:0]     arr_a_be;
    logic [ADDR_W-1:0]   arr_a_addr;
    logic [DATA_W-1:0]   arr_a_wdata;
    logic [DATA_W-1:0]   arr_a_rdata;
    logic [DATA_W-1:0]   arr_b_rdata;

    logic                byp_hit_q;
    logic [BE_W-1:0]     byp_be_q;
    logic [DATA_W-1:0]   byp_data_q;
    logic [DATA_W-1:0]   b_merged;

    logic                a_v1_q, b_v1_q;

    // NOTE: every signal driven here gets a default first, so no path can leave it unassigned and infer a latch.
    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        clr_we    = 1'b0;
        unique case (state_q)
            IDLE: begin
                clr_cnt_d = '0;
                state_d   = (CLEAR_ON_RESET != 0) ? CLEAR : READY;
            end
            CLEAR: begin
                clr_we    = 1'b1;
                clr_cnt_d = clr_cnt_q + 1'b1;
                // The spare top bit sets only after the last word is written.
                if (clr_cnt_d[ADDR_W]) state_d = READY;
            end
            READY: ;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            clr_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
        end
    end

    assign ready         = (state_q == READY);
    assign a_waitrequest = !ready;
    assign b_waitrequest = !ready;
    assign clear_done    = ready;

    // A simultaneous read and write on port A is a write only.
    assign a_wr_acc = ready && a_chipselect && a_write;
    assign a_rd_acc = ready && a_chipselect && a_read && !a_write;
    assign b_rd_acc = ready && b_chipselect && b_read;

    assign arr_a_we    = clr_we || a_wr_acc;
    assign arr_a_be    = clr_we ? '1 : a_byteenable;
    assign arr_a_addr  = clr_we ? clr_cnt_q[ADDR_W-1:0] : a_address;
    assign arr_a_wdata = clr_we ? '0 : a_writedata;

    onchip_ram_2p_array #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_array (
        .clk       (clk),
        .reset_n   (reset_n),
        .a_we_i    (arr_a_we),
        .a_re_i    (a_rd_acc),
        .a_be_i    (arr_a_be),
        .a_addr_i  (arr_a_addr),
        .a_wdata_i (arr_a_wdata),
        .a_rdata_o (arr_a_rdata),
        .b_we_i    (1'b0),
        .b_re_i    (b_rd_acc),
        .b_be_i    ('0),
        .b_addr_i  (b_address),
        .b_wdata_i ('0),
        .b_rdata_o (arr_b_rdata)
    );

    // The array reads old data on a same-address collision; capture the port A write so port B sees it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            byp_hit_q  <= 1'b0;
            byp_be_q   <= '0;
            byp_data_q <= '0;
            a_v1_q     <= 1'b0;
            b_v1_q     <= 1'b0;
        end else begin
            a_v1_q <= a_rd_acc;
            b_v1_q <= b_rd_acc;
            if (b_rd_acc) begin
                byp_hit_q  <= a_wr_acc && (a_address == b_address);
                byp_be_q   <= a_byteenable;
                byp_data_q <= a_writedata;
            end
        end
    end

    always_comb begin
        b_merged = arr_b_rdata;
        for (int i = 0; i < BE_W; i++) begin
            if (byp_hit_q && byp_be_q[i]) b_merged[8*i +: 8] = byp_data_q[8*i +: 8];
        end
    end

    generate
        if (READ_LATENCY == RD_LAT_2) begin : g_lat2
            logic                a_v2_q, b_v2_q;
            logic [DATA_W-1:0]   a_rd2_q, b_rd2_q;

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    a_v2_q  <= 1'b0;
                    b_v2_q  <= 1'b0;
                    a_rd2_q <= '0;
                    b_rd2_q <= '0;
                end else begin
                    a_v2_q <= a_v1_q;
                    b_v2_q <= b_v1_q;
                    if (a_v1_q) a_rd2_q <= arr_a_rdata;
                    if (b_v1_q) b_rd2_q <= b_merged;
                end
            end

            assign a_readdatavalid = a_v2_q;
            assign a_readdata      = a_rd2_q;
            assign b_readdatavalid = b_v2_q;
            assign b_readdata      = b_rd2_q;
        end else begin : g_lat1
            assign a_readdatavalid = a_v1_q;
            assign a_readdata      = arr_a_rdata;
            assign b_readdatavalid = b_v1_q;
            assign b_readdata      = b_merged;
        end
    endgenerate

endmodule

// File: tb/tb_onchip_ram_2p.sv
// Self-checking bench: latency-1 and latency-2 instances driven in lockstep against a write-first memory model.
module tb_onchip_ram_2p;

    localparam int DW    = 32;
    localparam int AW    = 4;
    localparam int DEPTH = 16;
    localparam int MAXE  = 4096;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            reset_n;
    logic            a_chipselect, a_read, a_write;
    logic [AW-1:0]   a_address;
    logic [3:0]      a_byteenable;
    logic [DW-1:0]   a_writedata;
    logic            b_chipselect, b_read;
    logic [AW-1:0]   b_address;

    logic [DW-1:0]   a_rdata [2];
    logic [DW-1:0]   b_rdata [2];
    logic            a_v [2];
    logic            b_v [2];
    logic            a_w [2];
    logic            b_w [2];
    logic            done [2];

    onchip_ram_2p #(.DATA_W(DW), .ADDR_W(AW), .READ_LATENCY(1), .CLEAR_ON_RESET(1)) dut_l1 (
        .clk(clk), .reset_n(reset_n),
        .a_chipselect(a_chipselect), .a_read(a_read), .a_write(a_write),
        .a_address(a_address), .a_byteenable(a_byteenable), .a_writedata(a_writedata),
        .a_readdata(a_rdata[0]), .a_readdatavalid(a_v[0]), .a_waitrequest(a_w[0]),
        .b_chipselect(b_chipselect), .b_read(b_read), .b_address(b_address),
        .b_readdata(b_rdata[0]), .b_readdatavalid(b_v[0]), .b_waitrequest(b_w[0]),
        .clear_done(done[0])
    );

    onchip_ram_2p #(.DATA_W(DW), .ADDR_W(AW), .READ_LATENCY(2), .CLEAR_ON_RESET(1)) dut_l2 (
        .clk(clk), .reset_n(reset_n),
        .a_chipselect(a_chipselect), .a_read(a_read), .a_write(a_write),
        .a_address(a_address), .a_byteenable(a_byteenable), .a_writedata(a_writedata),
        .a_readdata(a_rdata[1]), .a_readdatavalid(a_v[1]), .a_waitrequest(a_w[1]),
        .b_chipselect(b_chipselect), .b_read(b_read), .b_address(b_address),
        .b_readdata(b_rdata[1]), .b_readdatavalid(b_v[1]), .b_waitrequest(b_w[1]),
        .clear_done(done[1])
    );

    // Reference model: word memory plus, per port, the data of the read accepted at each edge.
    logic [DW-1:0] mem_m [DEPTH];
    bit            acc_v [2][MAXE];
    logic [DW-1:0] acc_d [2][MAXE];
    logic [DW-1:0] last  [2][2];
    int            edge_n;
    bit            model_ready;
    bit            exp_wait;
    int            checks;
    int            errors;

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        a_chipselect = 1'b0; a_read = 1'b0; a_write = 1'b0;
        a_address = '0; a_byteenable = '0; a_writedata = '0;
        b_chipselect = 1'b0; b_read = 1'b0; b_address = '0;
    endtask

    task automatic drive_a_write(input int addr, input logic [DW-1:0] data, input logic [3:0] be);
        a_chipselect = 1'b1; a_write = 1'b1;
        a_address = AW'(addr); a_writedata = data; a_byteenable = be;
    endtask

    task automatic drive_a_read(input int addr);
        a_chipselect = 1'b1; a_read = 1'b1; a_address = AW'(addr);
    endtask

    task automatic drive_b_read(input int addr);
        b_chipselect = 1'b1; b_read = 1'b1; b_address = AW'(addr);
    endtask

    // One clock: update the model from the sampled request, then compare all outputs of both instances.
    task automatic tick();
        @(posedge clk);
        edge_n++;
        if (model_ready) begin
            if (a_chipselect && a_write) begin
                for (int i = 0; i < 4; i++)
                    if (a_byteenable[i]) mem_m[a_address][8*i +: 8] = a_writedata[8*i +: 8];
            end
            if (a_chipselect && a_read && !a_write) begin
                acc_v[0][edge_n] = 1'b1;
                acc_d[0][edge_n] = mem_m[a_address];
            end
            if (b_chipselect && b_read) begin
                acc_v[1][edge_n] = 1'b1;
                acc_d[1][edge_n] = mem_m[b_address];
            end
        end
        #1;
        for (int d = 0; d < 2; d++) begin
            for (int p = 0; p < 2; p++) begin
                int      idx;
                bit      ev;
                logic    ov;
                logic [DW-1:0] od;
                idx = edge_n - d;
                ev  = (idx >= 0) && acc_v[p][idx];
                ov  = (p == 0) ? a_v[d] : b_v[d];
                od  = (p == 0) ? a_rdata[d] : b_rdata[d];
                if (ev) last[d][p] = acc_d[p][idx];
                check($sformatf("L%0d %s valid @%0d", d + 1, (p == 0) ? "A" : "B", edge_n), DW'(ov), DW'(ev));
                check($sformatf("L%0d %s data @%0d", d + 1, (p == 0) ? "A" : "B", edge_n), od, last[d][p]);
            end
            check($sformatf("L%0d A wait @%0d", d + 1, edge_n), DW'(a_w[d]), DW'(exp_wait));
            check($sformatf("L%0d B wait @%0d", d + 1, edge_n), DW'(b_w[d]), DW'(exp_wait));
            check($sformatf("L%0d clear_done @%0d", d + 1, edge_n), DW'(done[d]), DW'(!exp_wait));
        end
        idle_inputs();
    endtask

    task automatic assert_reset();
        reset_n     = 1'b0;
        model_ready = 1'b0;
        exp_wait    = 1'b1;
        for (int p = 0; p < 2; p++)
            for (int e = 0; e < MAXE; e++) acc_v[p][e] = 1'b0;
        for (int d = 0; d < 2; d++)
            for (int p = 0; p < 2; p++) last[d][p] = '0;
    endtask

    // Release reset: one cycle leaving IDLE, 16 cycles of sweep with waitrequest high, then ready.
    task automatic release_and_sweep();
        reset_n = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            if (i == 5) begin
                drive_a_read(0);
                drive_a_write(0, 32'hFFFF_FFFF, 4'hF);
                drive_b_read(0);
            end
            tick();
        end
        exp_wait = 1'b0;
        tick();
        model_ready = 1'b1;
        for (int i = 0; i < DEPTH; i++) mem_m[i] = '0;
    endtask

    task automatic read_all_words();
        for (int i = 0; i < DEPTH; i++) begin
            drive_a_read(i);
            drive_b_read(DEPTH - 1 - i);
            tick();
        end
        tick();
        tick();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        edge_n = 0;
        idle_inputs();
        assert_reset();

        repeat (3) tick();
        release_and_sweep();
        read_all_words();

        // Partial byte-lane write, then read back on the next cycle.
        drive_a_write(3, 32'hDEAD_BEEF, 4'b0101);
        tick();
        drive_a_read(3);
        tick();
        check("req033 L1 data", a_rdata[0], 32'h00AD_00EF);
        check("req033 L1 valid", DW'(a_v[0]), DW'(1));
        tick();
        check("req033 L2 data", a_rdata[1], 32'h00AD_00EF);
        check("req033 L2 valid", DW'(a_v[1]), DW'(1));

        // All-zero byteenable must leave the word unchanged.
        drive_a_write(3, 32'hFFFF_FFFF, 4'b0000);
        tick();
        drive_b_read(3);
        tick();
        tick();

        // Back-to-back port B reads.
        drive_a_write(0, 32'h1111_0000, 4'hF); tick();
        drive_a_write(1, 32'h2222_0001, 4'hF); tick();
        drive_a_write(2, 32'h3333_0002, 4'hF); tick();
        drive_b_read(0); tick();
        drive_b_read(1); tick();
        drive_b_read(2); tick();
        tick();
        tick();

        // Same-cycle write and port B read: full-word and partial-lane bypass.
        drive_a_write(5, 32'h1234_5678, 4'hF);
        drive_b_read(5);
        tick();
        check("req035 L1 bypass", b_rdata[0], 32'h1234_5678);
        tick();
        check("req035 L2 bypass", b_rdata[1], 32'h1234_5678);
        drive_a_write(5, 32'hAABB_CCDD, 4'b0011);
        drive_b_read(5);
        tick();
        check("partial bypass L1", b_rdata[0], 32'h1234_CCDD);

        // Read and write together on port A: write only, no response.
        drive_a_write(6, 32'h0BAD_F00D, 4'hF);
        a_read = 1'b1;
        tick();
        drive_a_read(6);
        tick();
        tick();
        tick();

        for (int i = 0; i < 300; i++) begin
            int unsigned op;
            op           = $urandom_range(0, 3);
            a_chipselect = ($urandom_range(0, 7) != 0);
            a_read       = op[0];
            a_write      = op[1];
            a_address    = AW'($urandom_range(0, DEPTH - 1));
            a_byteenable = 4'($urandom_range(0, 15));
            a_writedata  = $urandom;
            b_chipselect = ($urandom_range(0, 7) != 0);
            b_read       = ($urandom_range(0, 3) != 0);
            b_address    = ($urandom_range(0, 1) == 0) ? a_address : AW'($urandom_range(0, DEPTH - 1));
            tick();
        end
        tick();
        tick();

        // Reset with reads in flight, then again in the middle of the sweep.
        for (int i = 0; i < DEPTH; i++) begin
            drive_a_write(i, 32'hA5A5_0000 | i, 4'hF);
            tick();
        end
        drive_a_read(9);
        drive_b_read(10);
        tick();
        assert_reset();
        tick();
        tick();
        reset_n = 1'b1;
        repeat (8) tick();
        assert_reset();
        tick();
        tick();
        release_and_sweep();
        read_all_words();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/onchip_ram_2p.md
ONCHIP_RAM_2P -- requirements
Module: onchip_ram_2p

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, data word width, a multiple of 8.
REQ-002 The block SHALL have parameter ADDR_W, default 8, word address width; depth = 2**ADDR_W.
REQ-003 The block SHALL have parameter READ_LATENCY, default 1, legal values 1 or 2 cycles.
REQ-004 The block SHALL have parameter CLEAR_ON_RESET, default 1, enabling the post-reset zero-fill sweep.
REQ-005 The block SHALL have port clk, in, 1, the single clock for all logic.
REQ-006 The block SHALL have port reset_n, in, 1, asynchronous active-low reset.
REQ-007 The block SHALL have ports a_chipselect, a_read, a_write, in, 1 each, port A (read/write) strobes.
REQ-008 The block SHALL have port a_address, in, ADDR_W, port A word address.
REQ-009 The block SHALL have port a_byteenable, in, DATA_W/8, port A write byte lanes.
REQ-010 The block SHALL have ports a_writedata in and a_readdata out, DATA_W each.
REQ-011 The block SHALL have ports a_readdatavalid and a_waitrequest, out, 1 each.
REQ-012 The block SHALL have ports b_chipselect, b_read, in, 1 each, and b_address, in, ADDR_W; port B is read-only.
REQ-013 The block SHALL have ports b_readdata out, DATA_W; b_readdatavalid and b_waitrequest, out, 1 each.
REQ-014 The block SHALL have port clear_done, out, 1, high once the zero-fill sweep has completed.

Function
REQ-015 A port request SHALL be accepted on a rising clk edge when chipselect and (read or write) are high and waitrequest is low.
REQ-016 Port A write SHALL update only the byte lanes whose a_byteenable bit is 1; a write with a_byteenable all-zero SHALL leave memory unchanged.
REQ-017 Each accepted read SHALL produce exactly one readdatavalid pulse, exactly READ_LATENCY cycles after acceptance, with readdata valid in that same cycle.
REQ-018 Reads SHALL be fully pipelined: one accepted read per cycle per port, with readdatavalid pulses returned in issue order.
REQ-019 Simultaneous a_read and a_write in the same cycle SHALL be treated as a write only; no readdatavalid SHALL be generated.
REQ-020 Port A read of an address written by port A in the same cycle cannot occur (REQ-019); port A read one cycle after a write SHALL return the new data.
REQ-021 Port B read accepted in the same cycle as a port A write to the same address SHALL return the newly written data (write-first bypass, byte-lane merged).
REQ-022 readdata SHALL be held at its last value when readdatavalid is low.
REQ-023 Clear state machine SHALL have states IDLE, CLEAR, READY; after reset it enters CLEAR if CLEAR_ON_RESET=1, else READY.
REQ-024 In CLEAR, the block SHALL write zero to one word per cycle, from address 0 to 2**ADDR_W-1, then enter READY on the cycle after the last word; clear_done asserts upon entering READY.
REQ-025 a_waitrequest and b_waitrequest SHALL be high in IDLE and CLEAR and low in READY; no request SHALL be accepted while they are high.
REQ-026 The clear address counter SHALL be ADDR_W+1 bits wide, so that the terminal address does not wrap before the transition to READY is taken.

Reset
REQ-027 While reset_n is low: state=IDLE, clear counter=0, readdatavalid pipelines=0, readdata=0, clear_done=0, both waitrequests=1.
REQ-028 Assertion of reset_n mid-sweep or with reads in flight SHALL discard pending readdatavalid pulses; on release, the sweep SHALL restart from address 0.
REQ-029 Memory array contents SHALL NOT be reset by reset_n other than through the sweep.

Structure
REQ-030 Package onchip_ram_pkg SHALL hold the clear-state enumeration and the legal READ_LATENCY constants.
REQ-031 Storage SHALL be a single sub-module onchip_ram_2p_array (true dual-port, byte-enabled, registered read); pipeline, bypass and clear logic SHALL reside in onchip_ram_2p.

Verification
REQ-032 Release reset, ADDR_W=4 -> waitrequest high for exactly 16 cycles after leaving IDLE, then clear_done=1; reads of all 16 words return 0.
REQ-033 A write 0xDEADBEEF to addr 3 with byteenable 4'b0101, then A read of addr 3 -> 0x00AD00EF with readdatavalid exactly READ_LATENCY cycles later (test with both latencies).
REQ-034 Back-to-back B reads of addr 0,1,2 in consecutive cycles -> three consecutive readdatavalid pulses returning in order.
REQ-035 Same cycle: A writes 0x12345678 (all lanes) to addr 5 and B reads addr 5 -> B returns 0x12345678.
REQ-036 Assert reset_n low during the sweep at address 7 with a read in flight -> no readdatavalid; after release, the sweep restarts at 0 and completes the full depth.
